// File: rtl/mem_external_bus_ctrl.sv
// External bus sequencer for the MEM stage. Stores are posted into a write buffer.
// Loads stall the pipe until older stores have drained and the read data has returned.
module mem_external_bus_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid,
    input  logic [68:0] mem_req_data,
    input  logic        mem_clear,
    output logic        mem_stall_req,
    output logic        mem_read_done,
    output logic [31:0] mem_external_result,
    output logic        wbuf_empty,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_write,
    output logic [3:0]  bus_mask,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wdata,
    input  logic        bus_rdata_valid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [2:0] {IDLE, DRAIN, READ_REQ, READ_WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       fifo_mask [FIFO_DEPTH];
    logic [31:0]      fifo_addr [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             req_write, full, empty, push, pop, drain_state, read_req;

    assign req_write   = mem_req_data[68];
    assign full        = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign drain_state = (state == IDLE) || (state == DRAIN);
    assign push        = mem_req_valid && req_write && !full && (state != DONE);
    assign pop         = drain_state && !empty && bus_req_ready;
    assign read_req    = mem_req_valid && !req_write && !mem_clear;

    // A full buffer stalls even when a pop frees a slot this cycle: no bypass path.
    assign mem_stall_req = (mem_req_valid && req_write && full && (state != DONE)) ||
                           (read_req && (state != DONE)) ||
                           (state == READ_REQ) || (state == READ_WAIT);
    assign mem_read_done = (state == DONE);
    assign wbuf_empty    = empty && (state == IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mask[wr_ptr] <= mem_req_data[67:64];
            fifo_addr[wr_ptr] <= mem_req_data[63:32];
            fifo_data[wr_ptr] <= mem_req_data[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // rdata is only captured in READ_WAIT, so a strobe left over from an aborted read is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            mem_external_result <= '0;
        end else begin
            state <= state_nxt;
            if (state == READ_WAIT && bus_rdata_valid) mem_external_result <= bus_rdata;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus_req_valid = 1'b0;
        bus_write     = 1'b0;
        bus_mask      = '0;
        bus_address   = '0;
        bus_wdata     = '0;
        case (state)
            IDLE, DRAIN: begin
                bus_req_valid = !empty;
                bus_write     = 1'b1;
                bus_mask      = fifo_mask[rd_ptr];
                bus_address   = fifo_addr[rd_ptr];
                bus_wdata     = fifo_data[rd_ptr];
            end
            READ_REQ: begin
                bus_req_valid = 1'b1;
                bus_mask      = 4'hF;
                bus_address   = mem_req_data[63:32];
            end
            default: ;
        endcase
        case (state)
            IDLE:      if (read_req) state_nxt = empty ? READ_REQ : DRAIN;
            DRAIN: begin
                if (mem_clear)                          state_nxt = IDLE;
                else if (empty || (count == (PTR_W+1)'(1) && pop)) state_nxt = READ_REQ;
            end
            READ_REQ:  if (bus_req_ready)   state_nxt = READ_WAIT;
            READ_WAIT: if (bus_rdata_valid) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_external_bus_ctrl.sv
// Directed boundary cases plus a randomized run scored against a transaction-level
// model: program-order bus queue, buffer occupancy and per-address read data.
module tb_mem_external_bus_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_req_valid = 1'b0, mem_clear = 1'b0;
    logic [68:0] mem_req_data = '0;
    logic        mem_stall_req, mem_read_done, wbuf_empty;
    logic [31:0] mem_external_result;
    logic        bus_req_valid, bus_write;
    logic        bus_req_ready = 1'b0, bus_rdata_valid = 1'b0;
    logic [3:0]  bus_mask;
    logic [31:0] bus_address, bus_wdata;
    logic [31:0] bus_rdata = '0;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_external_bus_ctrl #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_data(mem_req_data), .mem_clear(mem_clear),
        .mem_stall_req(mem_stall_req), .mem_read_done(mem_read_done),
        .mem_external_result(mem_external_result), .wbuf_empty(wbuf_empty),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_write(bus_write),
        .bus_mask(bus_mask), .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_rdata_valid(bus_rdata_valid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rfun(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic drive(input logic v, input logic wr, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] d);
        mem_req_valid = v;
        mem_req_data  = {wr, m, a, d};
    endtask

    int nwr;
    logic [3:0] wmask [5] = '{4'h1, 4'h3, 4'hC, 4'hF, 4'h8};

    initial begin
        txn_t cur, t;
        txn_t exp_q[$];
        bit   have, rd_wait, exp_done, nxt_done;
        int   age, mcount, rd_delay, read_cnt, done_cnt;
        logic [31:0] rd_addr, done_addr;

        // reset state
        tick(); tick();
        chk("rst_stall", mem_stall_req, 0);
        chk("rst_done", mem_read_done, 0);
        chk("rst_result", mem_external_result, 0);
        chk("rst_busvalid", bus_req_valid, 0);
        chk("rst_wbuf_empty", wbuf_empty, 1);
        rst = 1'b0;

        // read latency from empty buffer, ready and rdata immediate
        tick(); drive(1, 0, 4'h0, 32'h0000_0100, 32'h0);
        bus_req_ready = 1; bus_rdata_valid = 1; bus_rdata = 32'hDEAD_BEEF; #1;
        chk("lat_c0_stall", mem_stall_req, 1);
        tick(); #1;
        chk("lat_c1_stall", mem_stall_req, 1);
        chk("lat_c1_valid", bus_req_valid, 1);
        chk("lat_c1_write", bus_write, 0);
        chk("lat_c1_mask", bus_mask, 4'hF);
        chk("lat_c1_addr", bus_address, 32'h0000_0100);
        chk("lat_c1_wdata", bus_wdata, 0);
        tick(); #1;
        chk("lat_c2_stall", mem_stall_req, 1);
        chk("lat_c2_done", mem_read_done, 0);
        tick(); #1;
        chk("lat_c3_stall", mem_stall_req, 0);
        chk("lat_c3_done", mem_read_done, 1);
        chk("lat_c3_result", mem_external_result, 32'hDEAD_BEEF);
        chk("lat_c3_wbuf_empty", wbuf_empty, 0);
        tick(); drive(0, 0, 0, 0, 0); bus_rdata_valid = 0; bus_req_ready = 0; #1;
        chk("lat_c4_done", mem_read_done, 0);
        chk("lat_c4_wbuf_empty", wbuf_empty, 1);

        // five writes against a stalled bus: the fifth stalls until one pop, then enqueues once
        for (int i = 0; i < 5; i++) begin
            tick(); drive(1, 1, wmask[i], 32'h1F80_1000 + 32'(4*i), 32'hA000_0000 + 32'(i)); #1;
            chk("full_stall", mem_stall_req, (i == 4) ? 1 : 0);
            if (i == 3) chk("three_nonempty", wbuf_empty, 0);
        end
        tick(); #1;
        chk("full_hold_stall", mem_stall_req, 1);
        nwr = 0;
        for (int c = 0; c < 10; c++) begin
            tick(); bus_req_ready = 1; mem_req_valid = (c < 2); #1;
            if (c < 2) chk("full_pop_stall", mem_stall_req, (c == 0) ? 1 : 0);
            if (bus_req_valid && bus_req_ready) begin
                chk("full_addr", bus_address, 32'h1F80_1000 + 32'(4*nwr));
                chk("full_mask", bus_mask, wmask[nwr % 5]);
                chk("full_wdata", bus_wdata, 32'hA000_0000 + 32'(nwr));
                nwr++;
            end
        end
        chk("full_nwrites", nwr, 5);
        chk("full_wbuf_empty", wbuf_empty, 1);

        // flush a load while it waits behind buffered stores
        bus_req_ready = 0;
        tick(); drive(1, 1, 4'h5, 32'h2000_0000, 32'h1111_1111); #1;
        tick(); drive(1, 1, 4'hA, 32'h2000_0004, 32'h2222_2222); #1;
        tick(); drive(1, 0, 4'h0, 32'h2000_0100, 32'h0); #1;
        chk("clr_read_stall", mem_stall_req, 1);
        tick(); mem_clear = 1; #1;
        chk("clr_drain_stall", mem_stall_req, 0);
        nwr = 0;
        for (int c = 0; c < 6; c++) begin
            tick(); drive(0, 0, 0, 0, 0); mem_clear = 0; bus_req_ready = 1; #1;
            if (bus_req_valid && bus_req_ready) begin
                chk("clr_only_writes", bus_write, 1);
                chk("clr_addr", bus_address, 32'h2000_0000 + 32'(4*nwr));
                nwr++;
            end
        end
        chk("clr_nwrites", nwr, 2);
        chk("clr_wbuf_empty", wbuf_empty, 1);

        // clear during READ_WAIT does not cancel an issued read
        tick(); drive(1, 0, 4'h0, 32'h0000_0200, 32'h0); bus_req_ready = 1; #1;
        tick(); #1;
        tick(); mem_clear = 1; #1;
        chk("rw_clr_stall", mem_stall_req, 1);
        tick(); bus_rdata_valid = 1; bus_rdata = 32'h1234_5678; #1;
        chk("rw_clr_stall2", mem_stall_req, 1);
        tick(); bus_rdata_valid = 0; #1;
        chk("rw_clr_done", mem_read_done, 1);
        chk("rw_clr_result", mem_external_result, 32'h1234_5678);
        tick(); drive(0, 0, 0, 0, 0); mem_clear = 0; #1;

        // async reset in READ_WAIT abandons the read; a late strobe is ignored
        tick(); drive(1, 0, 4'h0, 32'h0000_0300, 32'h0); bus_req_ready = 1; #1;
        tick(); #1;
        tick(); #1;
        rst = 1; drive(0, 0, 0, 0, 0); bus_req_ready = 0; #1;
        chk("mid_rst_busvalid", bus_req_valid, 0);
        chk("mid_rst_done", mem_read_done, 0);
        chk("mid_rst_result", mem_external_result, 0);
        chk("mid_rst_wbuf_empty", wbuf_empty, 1);
        chk("mid_rst_stall", mem_stall_req, 0);
        tick(); rst = 0;
        tick(); bus_rdata_valid = 1; bus_rdata = 32'hBAD0_BAD0; #1;
        tick(); bus_rdata_valid = 0; #1;
        chk("late_rdata_done", mem_read_done, 0);
        chk("late_rdata_result", mem_external_result, 0);

        // randomized traffic against the transaction model
        have = 0; rd_wait = 0; exp_done = 0; age = 0; mcount = 0; rd_delay = 0;
        read_cnt = 0; done_cnt = 0; rd_addr = '0; done_addr = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (!have && cyc < 3500 && $urandom_range(0, 3) != 0) begin
                cur.wr   = ($urandom_range(0, 9) < 6);
                cur.mask = cur.wr ? 4'($urandom) : 4'h0;
                cur.addr = {$urandom_range(0, 255), 2'b00};
                cur.data = cur.wr ? $urandom : 32'h0;
                have = 1; age = 0;
                exp_q.push_back(cur);
                if (!cur.wr) read_cnt++;
            end
            drive(have, cur.wr, cur.mask, cur.addr, cur.data);
            bus_req_ready   = ($urandom_range(0, 3) != 0);
            bus_rdata_valid = rd_wait && (rd_delay == 0);
            bus_rdata       = bus_rdata_valid ? rfun(rd_addr) : $urandom;
            #1;
            chk("r_done", mem_read_done, exp_done);
            if (exp_done) chk("r_result", mem_external_result, rfun(done_addr));
            if (!have)               chk("r_idle_stall", mem_stall_req, 0);
            else if (cur.wr)         chk("r_wstall", mem_stall_req, mcount == DEPTH);
            else                     chk("r_rstall", mem_stall_req, !exp_done);
            chk("r_wbuf_empty", wbuf_empty, (mcount == 0) && !(have && !cur.wr && age > 0));
            if (mem_read_done) done_cnt++;

            nxt_done = bus_rdata_valid;
            if (bus_rdata_valid) begin
                rd_wait = 0; done_addr = rd_addr;
            end else if (rd_wait) rd_delay--;

            if (bus_req_valid && bus_req_ready) begin
                if (exp_q.size() == 0) chk("r_unexpected_bus", 1, 0);
                else begin
                    t = exp_q.pop_front();
                    chk("r_bus_write", bus_write, t.wr);
                    chk("r_bus_addr", bus_address, t.addr);
                    chk("r_bus_mask", bus_mask, t.wr ? t.mask : 4'hF);
                    chk("r_bus_wdata", bus_wdata, t.wr ? t.data : 32'h0);
                    if (t.wr) mcount--;
                    else begin
                        rd_wait = 1; rd_delay = $urandom_range(0, 2); rd_addr = t.addr;
                    end
                end
            end
            if (have && !mem_stall_req) begin
                if (cur.wr) mcount++;
                have = 0;
            end
            if (have) age++;
            exp_done = nxt_done;
        end
        chk("r_queue_drained", exp_q.size(), 0);
        chk("r_buffer_drained", mcount, 0);
        chk("r_done_count", done_cnt, read_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
